riscv_core_dpath_vec_mem_unit: RTL and testbench
================================================

RISCV_CORE_DPATH_VEC_MEM_UNIT -- requirements
Module: riscv_core_dpath_vec_mem_unit

Interface
REQ-001 SHALL have no parameters: 8 elements x 32 bits, VLEN 256, all fixed.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 op_val  input  1  vector memory op valid.
REQ-005 op_rdy  output  1  unit can accept an op.
REQ-006 op_store  input  1  1=store, 0=load.
REQ-007 op_base  input  32  byte address of element 0.
REQ-008 op_stride  input  32  byte stride between elements.
REQ-009 op_vl  input  4  vector length.
REQ-010 op_vdata  input  256  store data; element i at bits [32i+31:32i].
REQ-011 memreq_val  output  1  memory request valid.
REQ-012 memreq_rdy  input  1  memory accepts request.
REQ-013 memreq_rw  output  1  1=write, 0=read.
REQ-014 memreq_addr  output  32  element byte address.
REQ-015 memreq_data  output  32  write data; 0 for reads.
REQ-016 memresp_val  input  1  memory response valid (reads and write acks).
REQ-017 memresp_data  input  32  read data.
REQ-018 done_val  output  1  one-cycle completion pulse.
REQ-019 vout  output  256  assembled load vector, feeds vector ALU vin0/vin1.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT, DONE; op_rdy=1 only in IDLE.
REQ-021 Op accepted when op_val & op_rdy in IDLE; SHALL latch op_store, op_base, op_stride, op_vl, op_vdata, clear element index to 0, and clear vout to 0 for loads.
REQ-022 Latched vl SHALL be clamped to 8 when op_vl > 8.
REQ-023 Accept with vl=0: next state DONE, no memory request issued, vout all-zero for loads.
REQ-024 Accept with vl>=1: next state REQ.
REQ-025 In REQ: memreq_val=1, memreq_addr = base + idx*stride (32-bit, wraps mod 2^32), memreq_rw = store, memreq_data = vdata element idx for stores else 0; hold all fields stable until memreq_rdy.
REQ-026 REQ -> WAIT on memreq_val & memreq_rdy; SHALL stay in REQ otherwise.
REQ-027 Exactly one outstanding request; memreq_val=0 in IDLE, WAIT, DONE.
REQ-028 In WAIT on memresp_val: load writes memresp_data into vout element idx; store discards data; if idx == vl-1 -> DONE, else idx+1 and -> REQ.
REQ-029 memresp_val outside WAIT SHALL be ignored with no state change.
REQ-030 Load vout elements at index >= vl SHALL read 0.
REQ-031 DONE: done_val=1 for exactly that cycle, then -> IDLE unconditionally.
REQ-032 vout SHALL hold its value from DONE until the next load op is accepted; store ops SHALL NOT modify vout.
REQ-033 Latency with memreq_rdy=1 and response one cycle after request: accept at cycle T, done_val at T+1+2*vl (vl=0 -> T+1).

Reset
REQ-034 Reset SHALL force IDLE, idx=0, vout=0, op_rdy=1, memreq_val=0, memreq_rw=0, memreq_addr=0, memreq_data=0, done_val=0.
REQ-035 Reset mid-operation SHALL abort the op with no done_val; a response arriving after reset SHALL be ignored per REQ-029.
REQ-036 Reset asserted together with op_val SHALL take priority; the op is not accepted.

Verification
REQ-037 Load base=0x100, stride=4, vl=8, memory returns addr value, rdy=1 -> requests 0x100..0x11C, vout element i = 0x100+4i, done_val at T+17.
REQ-038 Store base=0x200, stride=8, vl=3, vdata elements 0xA,0xB,0xC -> writes (0x200,0xA),(0x208,0xB),(0x210,0xC), vout unchanged, one done_val pulse.
REQ-039 Load vl=0 -> no memreq_val, done_val at T+1, vout=0; op_vl=15 -> exactly 8 requests.
REQ-040 memreq_rdy held low 3 cycles in REQ -> memreq_addr/data stable, no extra request, index unchanged.
REQ-041 base=0xFFFFFFFC, stride=4, vl=2 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-042 Reset in WAIT of element 2 then stray memresp_val -> IDLE, vout=0, no done_val, op_rdy=1.

Source files
------------

// File: rtl/riscv_core_dpath_vec_mem_unit.sv
// Strided vector load/store unit: walks up to eight 32-bit elements of one
// vector op with a single memory request in flight, assembling loads into vout.
module riscv_core_dpath_vec_mem_unit (
   input  logic         clk,
   input  logic         reset,
   input  logic         op_val,
   output logic         op_rdy,
   input  logic         op_store,
   input  logic [31:0]  op_base,
   input  logic [31:0]  op_stride,
   input  logic [3:0]   op_vl,
   input  logic [255:0] op_vdata,
   output logic         memreq_val,
   input  logic         memreq_rdy,
   output logic         memreq_rw,
   output logic [31:0]  memreq_addr,
   output logic [31:0]  memreq_data,
   input  logic         memresp_val,
   input  logic [31:0]  memresp_data,
   output logic         done_val,
   output logic [255:0] vout,
   output logic [1:0]   dbg_state
);

   // Handshakes: op and memreq transfer on a rising edge where valid and ready
   // are both high; memreq fields stay frozen while valid waits for ready.
   // memresp has no ready and is consumed only while waiting for a response.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t         state_q;
   state_t         state_d;

   logic           store_q;
   logic [31:0]    addr_q;
   logic [31:0]    stride_q;
   logic [3:0]     vl_q;
   logic [2:0]     idx_q;
   logic [255:0]   vdata_q;
   logic [255:0]   vout_q;

   logic [3:0]     vl_in;
   logic           accept;
   logic           resp_take;
   logic           last_elem;
   logic [7:0]     elem_lsb;

   assign vl_in     = (op_vl > 4'd8) ? 4'd8 : op_vl;
   assign accept    = (state_q == ST_IDLE) && op_val;
   assign resp_take = (state_q == ST_WAIT) && memresp_val;
   assign last_elem = ({1'b0, idx_q} == (vl_q - 4'd1));
   assign elem_lsb  = {idx_q, 5'b00000};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (op_val) begin
               state_d = (vl_in == 4'd0) ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            if (memreq_rdy) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (memresp_val) begin
               state_d = last_elem ? ST_DONE : ST_REQ;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // addr_q advances by stride per element, so it always equals base + idx*stride mod 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         store_q  <= 1'b0;
         addr_q   <= 32'h0;
         stride_q <= 32'h0;
         vl_q     <= 4'd0;
         idx_q    <= 3'd0;
         vdata_q  <= '0;
         vout_q   <= '0;
      end else if (accept) begin
         store_q  <= op_store;
         addr_q   <= op_base;
         stride_q <= op_stride;
         vl_q     <= vl_in;
         idx_q    <= 3'd0;
         vdata_q  <= op_vdata;
         if (!op_store) begin
            vout_q <= '0;
         end
      end else if (resp_take) begin
         if (!store_q) begin
            vout_q[elem_lsb +: 32] <= memresp_data;
         end
         if (!last_elem) begin
            idx_q  <= idx_q + 3'd1;
            addr_q <= addr_q + stride_q;
         end
      end
   end

   always_comb begin
      op_rdy      = 1'b0;
      memreq_val  = 1'b0;
      memreq_rw   = 1'b0;
      memreq_addr = 32'h0;
      memreq_data = 32'h0;
      done_val    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            op_rdy = 1'b1;
         end
         ST_REQ: begin
            memreq_val  = 1'b1;
            memreq_rw   = store_q;
            memreq_addr = addr_q;
            memreq_data = store_q ? vdata_q[elem_lsb +: 32] : 32'h0;
         end
         ST_DONE: begin
            done_val = 1'b1;
         end
         default: begin
            op_rdy = 1'b0;
         end
      endcase
   end

   assign vout      = vout_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_riscv_core_dpath_vec_mem_unit.sv
// Bench for the vector memory unit: a memory responder, a request/result
// scoreboard fed by a reference model, directed corner cases, then random ops.
module tb_riscv_core_dpath_vec_mem_unit;

   logic         clk = 1'b0;
   logic         reset;
   logic         op_val;
   logic         op_rdy;
   logic         op_store;
   logic [31:0]  op_base;
   logic [31:0]  op_stride;
   logic [3:0]   op_vl;
   logic [255:0] op_vdata;
   logic         memreq_val;
   logic         memreq_rdy;
   logic         memreq_rw;
   logic [31:0]  memreq_addr;
   logic [31:0]  memreq_data;
   logic         memresp_val;
   logic [31:0]  memresp_data;
   logic         done_val;
   logic [255:0] vout;
   logic [1:0]   dbg_state;

   riscv_core_dpath_vec_mem_unit dut (
      .clk          (clk),
      .reset        (reset),
      .op_val       (op_val),
      .op_rdy       (op_rdy),
      .op_store     (op_store),
      .op_base      (op_base),
      .op_stride    (op_stride),
      .op_vl        (op_vl),
      .op_vdata     (op_vdata),
      .memreq_val   (memreq_val),
      .memreq_rdy   (memreq_rdy),
      .memreq_rw    (memreq_rw),
      .memreq_addr  (memreq_addr),
      .memreq_data  (memreq_data),
      .memresp_val  (memresp_val),
      .memresp_data (memresp_data),
      .done_val     (done_val),
      .vout         (vout),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- counters / scoreboard ----------------
   int n_vec = 0;
   int n_err = 0;

   logic [64:0]  exp_req_q[$];
   logic [255:0] exp_vout_q[$];
   logic [31:0]  model_mem[logic [31:0]];
   logic [31:0]  phys_mem[logic [31:0]];
   logic [255:0] model_vout = '0;

   int hs_count   = 0;
   int done_count = 0;
   int done_cyc   = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return model_mem.exists(a) ? model_mem[a] : a;
   endfunction

   // Reference: element i lives at base + i*stride; vl saturates at 8.
   task automatic model_op(input logic st, input logic [31:0] base, input logic [31:0] stride,
                           input logic [3:0] vl, input logic [255:0] vd);
      int n;
      logic [255:0] v;
      logic [31:0] a;
      logic [31:0] d;
      n = (vl > 8) ? 8 : int'(vl);
      v = '0;
      for (int i = 0; i < n; i++) begin
         a = base + stride * 32'(i);
         if (st) begin
            d = vd[i*32 +: 32];
            exp_req_q.push_back({1'b1, a, d});
            model_mem[a] = d;
         end else begin
            exp_req_q.push_back({1'b0, a, 32'h0});
            v[i*32 +: 32] = model_rd(a);
         end
      end
      if (!st) model_vout = v;
      exp_vout_q.push_back(model_vout);
   endtask

   // ---------------- memory responder ----------------
   logic        fast_mode = 1'b1;
   logic        stray_en = 1'b0;
   int          hold_low = 0;
   int          force_stray = 0;
   logic        pending = 1'b0;
   int          delay = 0;
   logic [31:0] pend_data = 32'h0;

   initial begin
      memreq_rdy   = 1'b0;
      memresp_val  = 1'b0;
      memresp_data = 32'h0;
      forever begin
         @(negedge clk);
         if (!reset && memreq_val && memreq_rdy) begin
            pending = 1'b1;
            if (memreq_rw) begin
               phys_mem[memreq_addr] = memreq_data;
               pend_data = $urandom;
            end else begin
               pend_data = phys_mem.exists(memreq_addr) ? phys_mem[memreq_addr] : memreq_addr;
            end
            delay = fast_mode ? 0 : $urandom_range(0, 3);
         end
         @(posedge clk);
         #1;
         memresp_val  = 1'b0;
         memresp_data = 32'h0;
         if (pending) begin
            if (delay == 0) begin
               memresp_val  = 1'b1;
               memresp_data = pend_data;
               pending      = 1'b0;
            end else begin
               delay--;
            end
         end else if (force_stray > 0) begin
            memresp_val  = 1'b1;
            memresp_data = $urandom;
            force_stray--;
         end else if (stray_en && $urandom_range(0, 3) == 0) begin
            memresp_val  = 1'b1;
            memresp_data = $urandom;
         end
         if (hold_low > 0) begin
            memreq_rdy = 1'b0;
            hold_low--;
         end else begin
            memreq_rdy = fast_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
         end
      end
   end

   // ---------------- monitor ----------------
   logic         prev_stall = 1'b0;
   logic [64:0]  prev_req = '0;
   logic [255:0] hold_vout = '0;

   always @(negedge clk) begin
      logic [64:0] cur;
      if (reset) begin
         prev_stall = 1'b0;
         hold_vout  = '0;
      end else begin
         cur = {memreq_rw, memreq_addr, memreq_data};
         if (memreq_val) begin
            if (prev_stall) check("req_stable", cur, prev_req);
            if (memreq_rdy) begin
               hs_count++;
               if (exp_req_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_req: got %h expected none", cur);
               end else begin
                  check("memreq", cur, exp_req_q.pop_front());
               end
            end
            prev_stall = !memreq_rdy;
            prev_req   = cur;
         end else begin
            prev_stall = 1'b0;
         end
         if (op_rdy) begin
            check("idle_quiet", {memreq_val, done_val}, 2'b00);
            check("vout_hold", vout, hold_vout);
         end
         if (done_val) begin
            done_count++;
            done_cyc = cyc;
            if (exp_vout_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_done: vout %h", vout);
            end else begin
               hold_vout = exp_vout_q.pop_front();
               check("vout_done", vout, hold_vout);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic st, input logic [31:0] base, input logic [31:0] stride,
                        input logic [3:0] vl, input logic [255:0] vd, input int hold,
                        output int acc_cyc);
      int guard;
      op_store  = st;
      op_base   = base;
      op_stride = stride;
      op_vl     = vl;
      op_vdata  = vd;
      op_val    = 1'b1;
      guard     = 0;
      acc_cyc   = 0;
      forever begin
         @(negedge clk);
         if (op_rdy && !reset) break;
         guard++;
         if (guard > 300) begin
            n_vec++;
            n_err++;
            $display("FAIL op_accept_timeout: op_rdy never rose");
            break;
         end
      end
      hold_low = hold;
      model_op(st, base, stride, vl, vd);
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      op_val = 1'b0;
   endtask

   task automatic wait_done(input int start_count);
      int guard;
      guard = 0;
      while (done_count == start_count && guard < 400) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (done_count == start_count) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: no done_val within %0d cycles", guard);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t, d0, h0, guard;
      logic [255:0] vd;
      logic [255:0] ev;
      logic [31:0]  strides[5];
      logic [31:0]  r;

      strides = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hFFFFFFFC};
      reset = 1'b1; op_val = 1'b0; op_store = 1'b0; op_base = '0;
      op_stride = '0; op_vl = '0; op_vdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_op_rdy", op_rdy, 1'b1);
      check("rst_memreq", {memreq_val, memreq_rw, memreq_addr, memreq_data}, '0);
      check("rst_done", done_val, 1'b0);
      check("rst_vout", vout, '0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // load, stride 4, full length
      d0 = done_count; h0 = hs_count;
      issue(1'b0, 32'h100, 32'h4, 4'd8, '0, 0, t);
      wait_done(d0);
      check("lat_vl8", done_cyc - t, 17);
      check("hs_vl8", hs_count - h0, 8);
      ev = '0;
      for (int i = 0; i < 8; i++) ev[i*32 +: 32] = 32'h100 + 32'(4 * i);
      check("vout_load_addr", vout, ev);

      // store three elements, vout untouched
      vd = '0; vd[31:0] = 32'hA; vd[63:32] = 32'hB; vd[95:64] = 32'hC;
      d0 = done_count; h0 = hs_count;
      issue(1'b1, 32'h200, 32'h8, 4'd3, vd, 0, t);
      wait_done(d0);
      check("lat_store3", done_cyc - t, 7);
      check("hs_store3", hs_count - h0, 3);
      check("mem_208", phys_mem.exists(32'h208) ? phys_mem[32'h208] : 32'hX, 32'hB);
      check("vout_after_store", vout, ev);
      repeat (3) @(posedge clk);
      #1;
      check("one_done_store", done_count - d0, 1);

      // vl = 0
      d0 = done_count; h0 = hs_count;
      issue(1'b0, 32'h300, 32'h4, 4'd0, '0, 0, t);
      wait_done(d0);
      check("lat_vl0", done_cyc - t, 1);
      check("hs_vl0", hs_count - h0, 0);
      check("vout_vl0", vout, '0);

      // vl clamp
      d0 = done_count; h0 = hs_count;
      issue(1'b0, 32'h200, 32'h4, 4'd15, '0, 0, t);
      wait_done(d0);
      check("hs_vl15", hs_count - h0, 8);
      check("lat_vl15", done_cyc - t, 17);

      // memreq_rdy low for three REQ cycles
      d0 = done_count; h0 = hs_count;
      issue(1'b0, 32'h400, 32'h10, 4'd2, '0, 3, t);
      wait_done(d0);
      check("hs_stall", hs_count - h0, 2);
      check("lat_stall", done_cyc - t, 8);

      // address wrap
      d0 = done_count;
      issue(1'b0, 32'hFFFFFFFC, 32'h4, 4'd2, '0, 0, t);
      wait_done(d0);
      check("vout_wrap", vout[63:0], {32'h0, 32'hFFFFFFFC});

      // reset while waiting for element 2, then stray responses
      d0 = done_count; h0 = hs_count;
      issue(1'b0, 32'h800, 32'h4, 4'd4, '0, 0, t);
      guard = 0;
      while (hs_count < h0 + 3 && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("abort_reached_wait", hs_count - h0, 3);
      reset = 1'b1;
      exp_req_q.delete();
      exp_vout_q.delete();
      model_vout = '0;
      @(negedge clk);
      force_stray = 2;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_no_done", done_count - d0, 0);
      check("abort_op_rdy", op_rdy, 1'b1);
      check("abort_vout", vout, '0);
      check("abort_hs", hs_count - h0, 3);

      // reset and op_val together
      @(posedge clk);
      #1;
      d0 = done_count; h0 = hs_count;
      reset = 1'b1; op_val = 1'b1; op_store = 1'b0; op_base = 32'h500;
      op_stride = 32'h4; op_vl = 4'd3;
      @(posedge clk);
      #1;
      reset = 1'b0; op_val = 1'b0;
      repeat (5) @(negedge clk);
      check("rstop_no_req", hs_count - h0, 0);
      check("rstop_no_done", done_count - d0, 0);
      check("rstop_op_rdy", op_rdy, 1'b1);
      @(posedge clk);
      #1;

      // random traffic with back-pressure, response delay and stray responses
      fast_mode = 1'b0;
      stray_en  = 1'b1;
      for (int k = 0; k < 40; k++) begin
         vd = '0;
         for (int e = 0; e < 8; e++) begin
            r = $urandom;
            vd[e*32 +: 32] = r;
         end
         d0 = done_count;
         issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63) * 4),
               strides[$urandom_range(0, 4)], 4'($urandom_range(0, 15)), vd, 0, t);
         wait_done(d0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      stray_en = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("req_q_empty", exp_req_q.size(), 0);
      check("vout_q_empty", exp_vout_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
